// File: rtl/gf180_mem_pkg.sv
// Shared constants, state type and sizing helpers for the tiled gf180 SRAM.
package gf180_mem_pkg;

  localparam int MACRO_DEPTH = 512;
  localparam int MACRO_WIDTH = 8;
  localparam int MACRO_AW    = 9;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  // Number of macro rows needed to cover `depth` words.
  function automatic int banks(input int depth);
    return depth / MACRO_DEPTH;
  endfunction

  // Number of byte-wide macros needed to cover `width` bits.
  function automatic int lanes(input int width);
    return width / MACRO_WIDTH;
  endfunction

endpackage

// File: rtl/gf180_ram_bank.sv
// One bank: a row of byte-wide macros sharing select, write strobe and row address.
module gf180_ram_bank
  import gf180_mem_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                         clk,
  input  logic                         cen,
  input  logic                         gwen,
  input  logic [MACRO_AW-1:0]          a,
  input  logic [LANES*MACRO_WIDTH-1:0] d,
  input  logic [LANES*MACRO_WIDTH-1:0] wen,
  output logic [LANES*MACRO_WIDTH-1:0] q
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf180mcu_fd_ip_sram__sram512x8m8wm1 u_macro (
      .CLK  (clk),
      .CEN  (cen),
      .GWEN (gwen),
      .WEN  (wen[i*MACRO_WIDTH +: MACRO_WIDTH]),
      .A    (a),
      .D    (d[i*MACRO_WIDTH +: MACRO_WIDTH]),
      .Q    (q[i*MACRO_WIDTH +: MACRO_WIDTH])
    );
  end

endmodule

// File: rtl/gf180mcu_fd_ip_sram__sram512x8m8wm1.sv
// Behavioural model of the 512x8 gf180 SRAM macro (bit write mask, active-low controls).
// Q is only updated by reads; it holds while the macro is deselected or writing.
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] mem_r [512];

  // Synchronous array access: masked write or registered read.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem_r[A] <= (mem_r[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem_r[A];
      end
    end
  end

endmodule

// File: rtl/gf180_ram_tiled.sv
// Tiled SRAM: BANKS x LANES grid of 512x8 macros behind a valid/ready port,
// with a two-register read pipeline (S1 = macro access, S2 = output register)
// and an optional zero-fill sweep after reset.
module gf180_ram_tiled
  import gf180_mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 1024,
  parameter int INIT_ZERO = 1
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [$clog2(DEPTH)-1:0]    req_addr,
  input  logic [WIDTH-1:0]            req_wdata,
  input  logic [WIDTH/MACRO_WIDTH-1:0] req_be,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_rdata,
  output logic                        init_done
);

  localparam int LANES = lanes(WIDTH);
  localparam int BANKS = banks(DEPTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam init_state_e RST_STATE = (INIT_ZERO != 0) ? INIT : RUN;

  if ((WIDTH % MACRO_WIDTH != 0) || (DEPTH % MACRO_DEPTH != 0)) begin : g_bad_params
    $fatal(1, "gf180_ram_tiled: WIDTH must be a multiple of 8 and DEPTH a multiple of 512");
  end

  init_state_e         state_r, state_n_s;
  logic [MACRO_AW-1:0] init_cnt_r, init_cnt_n_s;
  logic                init_done_r;
  logic                s1_valid_r;
  logic [BW-1:0]       s1_bank_r;
  logic                rsp_valid_r;
  logic [WIDTH-1:0]    rsp_rdata_r;

  logic                s1_adv_s, req_ready_s, accept_s;
  logic [BW-1:0]       bank_s;
  logic [BANKS-1:0]    cen_s;
  logic                gwen_s;
  logic [MACRO_AW-1:0] a_s;
  logic [WIDTH-1:0]    d_s, wen_s, q_mux_s;
  logic [WIDTH-1:0]    q_all_s [BANKS];

  if (BANKS > 1) begin : g_bank_sel
    assign bank_s  = req_addr[AW-1:MACRO_AW];
    assign q_mux_s = q_all_s[s1_bank_r];
  end else begin : g_single_bank
    assign bank_s  = '0;
    assign q_mux_s = q_all_s[0];
  end

  // The output register may only change when it is empty or being drained;
  // S1 may take a new request when empty or when it can move into S2.
  assign s1_adv_s    = !rsp_valid_r || rsp_ready;
  assign req_ready_s = (state_r == RUN) && init_done_r && (!s1_valid_r || s1_adv_s);
  assign accept_s    = req_valid && req_ready_s;

  // Fill sequencer: sweep rows 0..511 once, then serve requests forever.
  always_comb begin
    state_n_s    = state_r;
    init_cnt_n_s = init_cnt_r;
    case (state_r)
      INIT: begin
        init_cnt_n_s = init_cnt_r + 9'd1;
        if (init_cnt_r == 9'd511) begin
          state_n_s = RUN;
        end else begin
          state_n_s = INIT;
        end
      end
      RUN: begin
        state_n_s = RUN;
      end
      default: begin
        state_n_s    = RST_STATE;
        init_cnt_n_s = 9'd0;
      end
    endcase
  end

  // FSM, fill counter and init_done registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r     <= RST_STATE;
      init_cnt_r  <= 9'd0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      init_cnt_r  <= init_cnt_n_s;
      init_done_r <= (state_n_s == RUN);
    end
  end

  // Macro controls: all banks zero-write during fill, else only the accepted bank.
  always_comb begin
    cen_s  = '1;
    gwen_s = 1'b1;
    wen_s  = '1;
    a_s    = req_addr[MACRO_AW-1:0];
    d_s    = req_wdata;
    case (state_r)
      INIT: begin
        cen_s  = '0;
        gwen_s = 1'b0;
        wen_s  = '0;
        a_s    = init_cnt_r;
        d_s    = '0;
      end
      RUN: begin
        if (accept_s) begin
          cen_s[bank_s] = 1'b0;
          gwen_s        = ~req_we;
          for (int i = 0; i < LANES; i++) begin
            wen_s[i*MACRO_WIDTH +: MACRO_WIDTH] = {MACRO_WIDTH{~req_be[i]}};
          end
        end else begin
          cen_s = '1;
        end
      end
      default: begin
        cen_s = '1;
      end
    endcase
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    gf180_ram_bank #(.LANES(LANES)) u_bank (
      .clk  (CLK),
      .cen  (cen_s[b]),
      .gwen (gwen_s),
      .a    (a_s),
      .d    (d_s),
      .wen  (wen_s),
      .q    (q_all_s[b])
    );
  end

  // Read pipeline: S1 tracks the read in the macro, S2 holds the response until taken.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid_r  <= 1'b0;
      s1_bank_r   <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      if (!s1_valid_r || s1_adv_s) begin
        s1_valid_r <= accept_s && !req_we;
        s1_bank_r  <= bank_s;
      end
      if (s1_adv_s) begin
        rsp_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          rsp_rdata_r <= q_mux_s;
        end
      end
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_gf180_ram_tiled.sv
// Self-checking bench for gf180_ram_tiled (WIDTH=32, DEPTH=1024, INIT_ZERO=1):
// directed vector table, backpressure / reset sequences and a random run,
// all read responses checked in order against a word-array scoreboard.
module tb_gf180_ram_tiled;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int LANES = 4;
  localparam int AW    = 10;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             req_valid, req_ready, req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [LANES-1:0] req_be;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             init_done;

  gf180_ram_tiled #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_ZERO(1)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rsp_count = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic        prev_hold;
  logic [31:0] prev_data;
  logic [31:0] sb_exp;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Count cycles from reset release until init_done; req_ready must stay low.
  task automatic init_wait(input string name);
    int   n;
    logic saw;
    n   = 0;
    saw = 1'b0;
    while (init_done !== 1'b1 && n < 600) begin
      if (req_ready) saw = 1'b1;
      tick();
      n++;
    end
    chk({name, " fill cycles"}, 32'(n), 32'd512);
    chk({name, " ready during fill"}, {31'd0, saw}, 32'd0);
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [3:0] be);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    #1;
    while (!req_ready && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send timeout addr=%03h", addr);
    end else begin
      chk("bank cen", {30'd0, dut.cen_s}, addr[9] ? 32'h1 : 32'h2);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin
    prev_hold = 1'b0;
    prev_data = 32'd0;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        exp_q.delete();
        prev_hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_rdata !== prev_data) begin
            errors++;
            if (errors < 50)
              $display("FAIL hold actual=%b/%08h required=1/%08h", rsp_valid, rsp_rdata, prev_data);
          end
        end
        prev_hold = rsp_valid && !rsp_ready;
        prev_data = rsp_rdata;
        if (rsp_valid && rsp_ready) begin
          rsp_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            if (errors < 50) $display("FAIL sb unexpected response actual=%08h required=none", rsp_rdata);
          end else begin
            sb_exp = exp_q.pop_front();
            if (rsp_rdata !== sb_exp) begin
              errors++;
              if (errors < 50) $display("FAIL sb rdata actual=%08h required=%08h", rsp_rdata, sb_exp);
            end
          end
        end
        if (req_valid && req_ready) begin
          if (req_we) begin
            for (int l = 0; l < LANES; l++)
              if (req_be[l]) model[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
          end else begin
            exp_q.push_back(model[req_addr]);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, n, base;
    logic rdy;

    vecs[0]  = '{1'b0, 10'h000, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 10'h3FF, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[2]  = '{1'b1, 10'h205, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[3]  = '{1'b0, 10'h205, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 10'h010, 32'hAAAA_AAAA, 4'hF, 32'h0000_0000};
    vecs[5]  = '{1'b1, 10'h010, 32'h1122_3344, 4'h5, 32'h0000_0000};
    vecs[6]  = '{1'b0, 10'h010, 32'h0000_0000, 4'h0, 32'hAA22_AA44};
    vecs[7]  = '{1'b1, 10'h011, 32'h5566_7788, 4'h0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 10'h011, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 10'h3FF, 32'hCAFE_F00D, 4'h8, 32'h0000_0000};
    vecs[10] = '{1'b0, 10'h3FF, 32'h0000_0000, 4'h0, 32'hCA00_0000};

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    RSTN = 1'b1;
    #2;
    RSTN = 1'b0;
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset init_done", {31'd0, init_done}, 32'd0);
    repeat (3) tick();
    RSTN = 1'b1;
    init_wait("init");

    // Directed vectors; each read checks one-edge S1 occupancy then the response.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d s1 not visible", i), {31'd0, rsp_valid}, 32'd0);
        tick();
        chk($sformatf("vec%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].exp);
      end
    end
    tick();

    // Backpressure: four back-to-back reads while the consumer stalls.
    for (int i = 1; i <= 4; i++) send(1'b1, 10'(i), 32'hA000_0000 | 32'(i), 4'hF);
    tick();
    base = rsp_count;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid = (acc < 4); req_we = 1'b0; req_addr = 10'(1 + acc); req_be = 4'h0;
      #1;
      rdy = req_ready && req_valid;
      tick();
      if (rdy) acc++;
    end
    req_valid = 1'b0;
    #1;
    chk("bp accepts while stalled", 32'(acc), 32'd2);
    chk("bp req_ready low", {31'd0, req_ready}, 32'd0);
    chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp rdata holds first", rsp_rdata, 32'hA000_0001);
    rsp_ready = 1'b1;
    n = 0;
    while (acc < 4 && n < 50) begin
      req_valid = 1'b1; req_addr = 10'(1 + acc);
      #1;
      rdy = req_ready;
      tick();
      if (rdy) acc++;
      n++;
    end
    req_valid = 1'b0;
    repeat (4) tick();
    chk("bp response count", 32'(rsp_count - base), 32'd4);
    chk("bp queue drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the fill sweep.
    RSTN = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    repeat (300) tick();
    RSTN = 1'b0;
    #1;
    chk("midinit init_done", {31'd0, init_done}, 32'd0);
    chk("midinit req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) tick();
    RSTN = 1'b1;
    init_wait("midinit");

    // Reset with a response held and a read in S1.
    send(1'b1, 10'h007, 32'h1234_5678, 4'hF);
    rsp_ready = 1'b0;
    send(1'b0, 10'h007, 32'h0, 4'h0);
    send(1'b0, 10'h008, 32'h0, 4'h0);
    chk("midrun rsp held", {31'd0, rsp_valid}, 32'd1);
    RSTN = 1'b0;
    #1;
    chk("midrun rsp_valid drops", {31'd0, rsp_valid}, 32'd0);
    chk("midrun rdata cleared", rsp_rdata, 32'd0);
    repeat (2) tick();
    RSTN = 1'b1;
    rsp_ready = 1'b1;
    init_wait("midrun");
    send(1'b0, 10'h007, 32'h0, 4'h0);
    tick();
    chk("refill rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("refill rdata zero", rsp_rdata, 32'd0);
    tick();

    // Random traffic on a small address window spanning both banks.
    for (int c = 0; c < 20000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 1) != 0);
      req_addr  = {1'($urandom_range(0, 1)), 5'd0, 4'($urandom_range(0, 15))};
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) tick();
    chk("stress queue drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
